// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive path with a one-byte holding register.
// Synchronises the raw line, samples each bit at its centre, delivers bytes
// through a valid/ready pop interface and keeps sticky framing/overrun flags.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       ErrorClear,
  output logic       FramingError,
  output logic       Overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;

  localparam logic [CW-1:0] SYM_LAST    = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  // Two-flop synchroniser; only rx_s_q is visible to the receive logic.
  logic sync1_q;
  logic rx_s_q;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;

  // One-cycle strobes from the FSM on the stop-sample cycle.
  logic stop_good;
  logic stop_bad;
  logic pop;
  logic ov_set;

  // Synchronise the asynchronous serial line; idle level is high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= SIn;
      rx_s_q  <= sync1_q;
    end
  end

  // Frame FSM: start qualification, centre sampling of data and stop bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == SYM_LAST) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Half a symbol in: confirm the start bit is still low.
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // Timer was aligned to the start-bit centre, so each wrap is a bit centre.
        if (cnt_q == SYM_LAST) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            cnt_d   = '0;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == SYM_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            stop_good = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line must return high before a new start is accepted,
        // so a break reports a single framing error.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, bit timer, bit index and shift register state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign pop = valid_q & DataOutReady;

  // Holding register: a pop and a delivery in the same cycle keep it full with the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_set  = 1'b0;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (stop_good) begin
      if (!valid_q || pop) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_set = 1'b1;
      end
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_comb begin
    fe_d = fe_q;
    ov_d = ov_q;
    if (ErrorClear) begin
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (stop_bad) begin
      fe_d = 1'b1;
    end
    if (ov_set) begin
      ov_d = 1'b1;
    end
  end

  // Output-side registers: holding byte, valid and error flags.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign DataOut      = data_q;
  assign DataOutValid = valid_q;
  assign FramingError = fe_q;
  assign Overrun      = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at 10 clocks per bit.
module tb_uart_receiver;

  localparam int SYM = 10;

  logic       Clock;
  logic       Reset;
  logic       SIn;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       ErrorClear;
  logic       FramingError;
  logic       Overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int rise_cyc  = -1000;
  logic prev_valid = 1'b0;

  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SIn         (SIn),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady),
    .ErrorClear  (ErrorClear),
    .FramingError(FramingError),
    .Overrun     (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Record the cycle at which DataOutValid rises, sampled away from the active edge.
  always @(negedge Clock) begin
    if (DataOutValid && !prev_valid) rise_cyc = cyc;
    prev_valid = DataOutValid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected byte and compare it with the holding register.
  task automatic sb_compare(input string tag);
    logic [7:0] e;
    check_eq({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_data"}, DataOut, e);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Drive one 8N1 frame; called and returns on a negative clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    SIn = 1'b0;
    start_cyc = cyc;
    wait_cycles(SYM);
    for (int i = 0; i < 8; i++) begin
      SIn = b[i];
      wait_cycles(SYM);
    end
    SIn = stop_bit;
    wait_cycles(SYM);
    SIn = 1'b1;
  endtask

  task automatic pulse_ready();
    DataOutReady = 1'b1;
    wait_cycles(1);
    DataOutReady = 1'b0;
  endtask

  task automatic pulse_clear();
    ErrorClear = 1'b1;
    wait_cycles(1);
    ErrorClear = 1'b0;
  endtask

  initial begin
    int lat;
    Reset        = 1'b0;
    SIn          = 1'b1;
    DataOutReady = 1'b0;
    ErrorClear   = 1'b0;
    wait_cycles(3);
    check_eq("rst_data",  DataOut, 8'h00);
    check_eq("rst_valid", DataOutValid, 1'b0);
    check_eq("rst_fe",    FramingError, 1'b0);
    check_eq("rst_ov",    Overrun, 1'b0);
    Reset = 1'b1;
    wait_cycles(5);

    // 1: single frame, latency from start edge to valid
    rise_cyc = -1000;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    lat = rise_cyc - start_cyc;
    check_eq("t1_latency_98pm1", (lat >= 97 && lat <= 99), 1'b1);
    check_eq("t1_valid", DataOutValid, 1'b1);
    sb_compare("t1");
    check_eq("t1_fe", FramingError, 1'b0);
    check_eq("t1_ov", Overrun, 1'b0);

    // 2: pop, then a pop attempt while empty
    pulse_ready();
    check_eq("t2_valid_after_pop", DataOutValid, 1'b0);
    check_eq("t2_data_kept", DataOut, 8'hA5);
    pulse_ready();
    check_eq("t2_valid_second", DataOutValid, 1'b0);
    check_eq("t2_data_second", DataOut, 8'hA5);

    // 3: back-to-back frames without popping -> overrun, first byte kept
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    check_eq("t3_valid", DataOutValid, 1'b1);
    check_eq("t3_ov", Overrun, 1'b1);
    sb_compare("t3");
    pulse_clear();
    check_eq("t3_ov_cleared", Overrun, 1'b0);
    check_eq("t3_data_after_clear", DataOut, 8'h3C);
    pulse_ready();
    check_eq("t3_valid_popped", DataOutValid, 1'b0);

    // 4: framing error, then a good frame
    send_frame(8'h55, 1'b0);
    wait_cycles(5);
    check_eq("t4_fe", FramingError, 1'b1);
    check_eq("t4_valid", DataOutValid, 1'b0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check_eq("t4_valid_good", DataOutValid, 1'b1);
    sb_compare("t4");
    check_eq("t4_fe_sticky", FramingError, 1'b1);
    pulse_clear();
    check_eq("t4_fe_cleared", FramingError, 1'b0);
    pulse_ready();

    // 5: short low glitch is rejected silently
    SIn = 1'b0;
    wait_cycles(3);
    SIn = 1'b1;
    wait_cycles(2 * SYM);
    check_eq("t5_valid", DataOutValid, 1'b0);
    check_eq("t5_fe", FramingError, 1'b0);
    check_eq("t5_ov", Overrun, 1'b0);

    // 6: reset in the middle of a data phase, then a clean frame
    SIn = 1'b0;
    wait_cycles(SYM);
    SIn = 1'b1;
    wait_cycles(SYM);
    SIn = 1'b0;
    wait_cycles(SYM + 3);
    Reset = 1'b0;
    SIn   = 1'b1;
    wait_cycles(3);
    check_eq("t6_rst_data",  DataOut, 8'h00);
    check_eq("t6_rst_valid", DataOutValid, 1'b0);
    check_eq("t6_rst_fe",    FramingError, 1'b0);
    check_eq("t6_rst_ov",    Overrun, 1'b0);
    Reset = 1'b1;
    wait_cycles(5);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    check_eq("t6_valid", DataOutValid, 1'b1);
    sb_compare("t6");
    check_eq("t6_fe", FramingError, 1'b0);
    check_eq("t6_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
